// File: rtl/ppl_pkg.sv
// Shared types for the fetch-stage PC generator: FSM state encoding and the
// redirect priority encoding used by both the selector and the pending latch.
package ppl_pkg;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Redirect priority; a larger value wins. NONE doubles as "pending empty".
  typedef enum logic [1:0] {
    PRIO_NONE = 2'd0,
    PRIO_JMP  = 2'd1,
    PRIO_BR   = 2'd2,
    PRIO_EXC  = 2'd3
  } prio_t;

endpackage : ppl_pkg

// File: rtl/ppl_redir_sel.sv
// Combinational redirect selector: picks the highest-priority live redirect,
// aligns its target to STEP, compares it with the pending redirect and
// produces the PC to load on the next advance.
module ppl_redir_sel
  import ppl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             exc_valid,
  input  logic [WIDTH-1:0] exc_pc,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_pc,
  input  logic             jmp_valid,
  input  logic [WIDTH-1:0] jmp_pc,
  input  prio_t            pend_prio,
  input  logic [WIDTH-1:0] pend_pc,
  input  logic [WIDTH-1:0] pc,
  output prio_t            cur_prio,
  output logic [WIDTH-1:0] cur_pc,
  output logic             cur_wins,
  output logic [WIDTH-1:0] next_pc
);

  // Clears the low log2(STEP) bits so every target is STEP-aligned.
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(STEP - 1));

  logic [WIDTH-1:0] raw_pc;

  // Fixed-priority pick: exception over branch over jump.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    cur_prio = PRIO_NONE;
    raw_pc   = '0;
    if (exc_valid) begin
      cur_prio = PRIO_EXC;
      raw_pc   = exc_pc;
    end else if (br_valid) begin
      cur_prio = PRIO_BR;
      raw_pc   = br_pc;
    end else if (jmp_valid) begin
      cur_prio = PRIO_JMP;
      raw_pc   = jmp_pc;
    end
  end

  assign cur_pc = raw_pc & ALIGN_MASK;

  // A live redirect beats the pending one on equal or higher priority; an
  // empty pending slot is PRIO_NONE, so any live redirect wins it.
  assign cur_wins = (cur_prio != PRIO_NONE) && (cur_prio >= pend_prio);

  // Advance target: winning live redirect, then pending, then sequential
  // (wraps modulo 2^WIDTH).
  always_comb begin
    next_pc = pc + WIDTH'(STEP);
    if (cur_wins) begin
      next_pc = cur_pc;
    end else if (pend_prio != PRIO_NONE) begin
      next_pc = pend_pc;
    end
  end

endmodule : ppl_redir_sel

// File: rtl/ppl_pc_gen.sv
// Fetch-stage PC generator: prioritised redirects, a pending-redirect latch
// that survives stalls and slow fetches, a req/ack handshake toward imem and
// a valid flag that squashes wrong-path fetches.
module ppl_pc_gen
  import ppl_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               STEP      = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(-STEP)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             exc_valid_i,
  input  logic [WIDTH-1:0] exc_pc_i,
  input  logic             br_valid_i,
  input  logic [WIDTH-1:0] br_pc_i,
  input  logic             jmp_valid_i,
  input  logic [WIDTH-1:0] jmp_pc_i,
  output logic             fetch_req_o,
  input  logic             fetch_ack_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             fetch_valid_o,
  output logic             pend_o
);

  state_t           state;
  prio_t            pend_prio;
  logic [WIDTH-1:0] pend_pc;
  prio_t            cur_prio;
  logic [WIDTH-1:0] cur_pc;
  logic             cur_wins;
  logic [WIDTH-1:0] next_pc;
  logic             advance;

  ppl_redir_sel #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_redir_sel (
    .exc_valid (exc_valid_i),
    .exc_pc    (exc_pc_i),
    .br_valid  (br_valid_i),
    .br_pc     (br_pc_i),
    .jmp_valid (jmp_valid_i),
    .jmp_pc    (jmp_pc_i),
    .pend_prio (pend_prio),
    .pend_pc   (pend_pc),
    .pc        (pc_o),
    .cur_prio  (cur_prio),
    .cur_pc    (cur_pc),
    .cur_wins  (cur_wins),
    .next_pc   (next_pc)
  );

  // The PC moves only on these cycles; stall is ignored in BOOT and the PC
  // never changes while a request is outstanding.
  assign advance = (state == ST_BOOT)
                || ((state == ST_REQ)  && fetch_ack_i && !stall_i)
                || ((state == ST_HOLD) && !stall_i);

  assign pend_o = (pend_prio != PRIO_NONE);

  // Any redirect seen at or before the ack marks that fetch as wrong-path.
  assign fetch_valid_o = (state == ST_REQ) && fetch_ack_i && !pend_o
                      && (cur_prio == PRIO_NONE);

  // Fetch FSM with a registered request output.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      state       <= ST_BOOT;
      fetch_req_o <= 1'b0;
    end else begin
      unique case (state)
        ST_BOOT: begin
          state       <= ST_REQ;
          fetch_req_o <= 1'b1;
        end
        ST_REQ: begin
          if (fetch_ack_i && stall_i) begin
            state       <= ST_HOLD;
            fetch_req_o <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall_i) begin
            state       <= ST_REQ;
            fetch_req_o <= 1'b1;
          end
        end
        default: begin
          state       <= ST_BOOT;
          fetch_req_o <= 1'b0;
        end
      endcase
    end
  end

  // PC register and pending-redirect latch: advance consumes the pending
  // redirect; otherwise a live redirect of equal or higher priority replaces it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_o      <= RESET_VEC;
      pend_prio <= PRIO_NONE;
      pend_pc   <= '0;
    end else if (advance) begin
      pc_o      <= next_pc;
      pend_prio <= PRIO_NONE;
      pend_pc   <= '0;
    end else if (cur_wins) begin
      pend_prio <= cur_prio;
      pend_pc   <= cur_pc;
    end
  end

endmodule : ppl_pc_gen

// File: tb/tb_ppl_pc_gen.sv
// Directed bench for ppl_pc_gen: boot sequence, stall/hold, pending
// redirects, priority resolution, alignment, wrap-around and async reset.
module tb_ppl_pc_gen;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             stall_i;
  logic             exc_valid_i;
  logic [WIDTH-1:0] exc_pc_i;
  logic             br_valid_i;
  logic [WIDTH-1:0] br_pc_i;
  logic             jmp_valid_i;
  logic [WIDTH-1:0] jmp_pc_i;
  logic             fetch_req_o;
  logic             fetch_ack_i;
  logic [WIDTH-1:0] pc_o;
  logic             fetch_valid_o;
  logic             pend_o;

  int errors = 0;
  int checks = 0;

  ppl_pc_gen #(
    .WIDTH (WIDTH),
    .STEP  (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .exc_valid_i   (exc_valid_i),
    .exc_pc_i      (exc_pc_i),
    .br_valid_i    (br_valid_i),
    .br_pc_i       (br_pc_i),
    .jmp_valid_i   (jmp_valid_i),
    .jmp_pc_i      (jmp_pc_i),
    .fetch_req_o   (fetch_req_o),
    .fetch_ack_i   (fetch_ack_i),
    .pc_o          (pc_o),
    .fetch_valid_o (fetch_valid_o),
    .pend_o        (pend_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Move just past the next rising edge; inputs are then changed mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic no_redir();
    exc_valid_i = 1'b0; br_valid_i = 1'b0; jmp_valid_i = 1'b0;
  endtask

  initial begin
    reset = 1'b0; stall_i = 1'b0; fetch_ack_i = 1'b1;
    exc_pc_i = '0; br_pc_i = '0; jmp_pc_i = '0;
    no_redir();

    // 1. Reset values and boot sequence.
    #12;
    check("rst_pc",    pc_o, 32'hFFFF_FFFC);
    check("rst_req",   fetch_req_o, 0);
    check("rst_valid", fetch_valid_o, 0);
    check("rst_pend",  pend_o, 0);
    @(negedge clk); reset = 1'b1; settle();
    check("boot_pc",  pc_o, 32'hFFFF_FFFC);
    check("boot_req", fetch_req_o, 0);
    check("boot_valid", fetch_valid_o, 0);
    tick();
    check("seq0_pc", pc_o, 32'h0);
    check("seq0_req", fetch_req_o, 1);
    check("seq0_valid", fetch_valid_o, 1);
    tick();
    check("seq4_pc", pc_o, 32'h4);
    check("seq4_valid", fetch_valid_o, 1);
    tick();
    check("seq8_pc", pc_o, 32'h8);

    // 2. Stall on the ack at pc 8 for three cycles.
    stall_i = 1'b1; settle();
    check("stall_ack_valid", fetch_valid_o, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("hold_pc", pc_o, 32'h8);
      check("hold_req", fetch_req_o, 0);
      check("hold_valid", fetch_valid_o, 0);
    end
    tick();
    stall_i = 1'b0; settle();
    check("hold_last_pc", pc_o, 32'h8);
    tick();
    check("unstall_pc", pc_o, 32'hC);
    check("unstall_req", fetch_req_o, 1);

    // 3. Branch while waiting for ack: latched, fetch squashed, then applied.
    fetch_ack_i = 1'b0; br_valid_i = 1'b1; br_pc_i = 32'h100; settle();
    check("wait_valid", fetch_valid_o, 0);
    tick();
    no_redir(); settle();
    check("br_pend", pend_o, 1);
    check("br_pend_pc", pc_o, 32'hC);
    fetch_ack_i = 1'b1; settle();
    check("br_squash", fetch_valid_o, 0);
    tick();
    check("br_pc", pc_o, 32'h100);
    check("br_pend_clr", pend_o, 0);
    check("br_tgt_valid", fetch_valid_o, 1);

    // 4. Simultaneous redirects: exception wins, applied without pending.
    exc_valid_i = 1'b1; exc_pc_i = 32'h80;
    br_valid_i  = 1'b1; br_pc_i  = 32'h200;
    jmp_valid_i = 1'b1; jmp_pc_i = 32'h300; settle();
    check("all3_squash", fetch_valid_o, 0);
    tick();
    no_redir(); settle();
    check("exc_pc", pc_o, 32'h80);
    check("exc_pend", pend_o, 0);
    // jmp pending, then br overwrites it.
    fetch_ack_i = 1'b0; jmp_valid_i = 1'b1; jmp_pc_i = 32'h300;
    tick();
    no_redir(); br_valid_i = 1'b1; br_pc_i = 32'h200;
    tick();
    no_redir(); fetch_ack_i = 1'b1; settle();
    check("ovr_pend", pend_o, 1);
    check("ovr_squash", fetch_valid_o, 0);
    tick();
    check("ovr_pc", pc_o, 32'h200);
    // br pending, then a later jmp is dropped.
    fetch_ack_i = 1'b0; br_valid_i = 1'b1; br_pc_i = 32'h400;
    tick();
    no_redir(); jmp_valid_i = 1'b1; jmp_pc_i = 32'h300;
    tick();
    no_redir(); fetch_ack_i = 1'b1;
    tick();
    check("keep_pc", pc_o, 32'h400);

    // 5. Alignment and wrap-around.
    jmp_valid_i = 1'b1; jmp_pc_i = 32'h103;
    tick();
    check("align_pc", pc_o, 32'h100);
    jmp_pc_i = 32'hFFFF_FFFC;
    tick();
    no_redir();
    check("top_pc", pc_o, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc", pc_o, 32'h0);

    // 6. Reset mid-HOLD with a pending redirect.
    stall_i = 1'b1;
    tick();
    br_valid_i = 1'b1; br_pc_i = 32'h500;
    tick();
    no_redir(); settle();
    check("hold_pend", pend_o, 1);
    check("hold2_pc", pc_o, 32'h0);
    #1 reset = 1'b0; settle();
    check("arst_pc", pc_o, 32'hFFFF_FFFC);
    check("arst_pend", pend_o, 0);
    check("arst_req", fetch_req_o, 0);
    stall_i = 1'b0;
    @(negedge clk); reset = 1'b1; settle();
    check("reboot_pc", pc_o, 32'hFFFF_FFFC);
    tick();
    check("reboot_seq0", pc_o, 32'h0);
    check("reboot_pend", pend_o, 0);
    tick();
    check("reboot_seq4", pc_o, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ppl_pc_gen
